write_s_block: RTL and testbench

- Final stage of the IDCT pipeline; sits directly downstream of the S-matrix compute stage.
- After start, reads one finished 8x8 S block from the S dual-port RAM using both ports at once.
- Scales and clips each value to an 8-bit pixel, packs two pixels per 16-bit word and writes the 32 words to external SRAM.
- Writes go to the block's raster position in the Y, U or V plane.

---
 rtl/write_s_block.sv | 210 +++++++++++++++++++++
 tb/tb_write_s_block.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_s_block.sv
`default_nettype none
// ============================================================================
//  Module   : write_s_block
//  Purpose  : Last IDCT pipeline stage. Reads a finished 8x8 S block from the
//             dual-port S RAM (even pixel on port a, odd pixel on port b),
//             scales and clips each value to an 8-bit pixel, packs two pixels
//             per 16-bit word and writes 32 words to the block's raster
//             position in the Y, U or V plane of external SRAM.
//  Ports    : Clock_50        - system clock, rising edge
//             Reset           - synchronous active-high reset
//             start           - request pulse, sampled only in IDLE
//             plane           - 0=Y 1=U 2=V 3=invalid (no writes), latched
//             block_row/col   - block position, latched at start
//             Address_S_a/b   - S RAM read addresses (even/odd pixel)
//             Data_out_S_a/b  - S RAM read data, 1-cycle latency
//             SRAM_address    - external SRAM word address
//             SRAM_write_data - {even pixel, odd pixel}
//             SRAM_we_n       - active-low write enable
//             busy / finish   - in-flight flag / one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module write_s_block #(
  parameter int SHIFT            = 16,
  parameter int Y_OFFSET         = 0,
  parameter int U_OFFSET         = 38400,
  parameter int V_OFFSET         = 57600,
  parameter int Y_WORDS_PER_ROW  = 160,
  parameter int UV_WORDS_PER_ROW = 80
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  plane,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [6:0]  Address_S_a,
  input  logic [31:0] Data_out_S_a,
  output logic [6:0]  Address_S_b,
  input  logic [31:0] Data_out_S_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        finish
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEADIN1 = 3'd1,
    S_LEADIN2 = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  plane_q, plane_d;
  logic [17:0] row_base_q, row_base_d;   // SRAM address of word 0 of current S row
  logic [5:0]  wr_idx_q, wr_idx_d;       // index of next word to write (32 = all done)
  logic [6:0]  addr_a_q, addr_a_d;
  logic [6:0]  addr_b_q, addr_b_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic        busy_q, busy_d;
  logic        finish_q, finish_d;

  logic [17:0] w_plane_base;
  logic [17:0] w_wpr_in;
  logic [17:0] w_start_base;
  logic [17:0] w_wpr_q;
  logic [4:0]  w_rd_k;
  logic        w_do_write;
  logic        w_do_adv;

  // Scale by arithmetic shift and saturate to the 0..255 pixel range.
  function automatic logic [7:0] clip_pix(input logic [31:0] s);
    logic signed [31:0] p;
    p = $signed(s) >>> SHIFT;
    if (p < 0)
      return 8'h00;
    else if (p > 32'sd255)
      return 8'hFF;
    else
      return p[7:0];
  endfunction

  // Start-of-block row base, computed once from the live inputs on the
  // accepting edge; per-word addresses afterwards only add WPR per row.
  always_comb begin
    case (plane)
      2'd1:    w_plane_base = 18'(U_OFFSET);
      2'd2:    w_plane_base = 18'(V_OFFSET);
      default: w_plane_base = 18'(Y_OFFSET);
    endcase
    w_wpr_in     = (plane == 2'd0) ? 18'(Y_WORDS_PER_ROW) : 18'(UV_WORDS_PER_ROW);
    w_start_base = w_plane_base
                 + 18'({block_row, 3'b000}) * w_wpr_in
                 + 18'({block_col, 2'b00});
  end

  assign w_wpr_q = (plane_q == 2'd0) ? 18'(Y_WORDS_PER_ROW) : 18'(UV_WORDS_PER_ROW);
  // Word index currently on the read ports: Address_S_a = 2k.
  assign w_rd_k  = addr_a_q[5:1];

  always_comb begin
    state_d     = state_q;
    plane_d     = plane_q;
    row_base_d  = row_base_q;
    wr_idx_d    = wr_idx_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    sram_addr_d = sram_addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    busy_d      = busy_q;
    finish_d    = 1'b0;
    w_do_write  = 1'b0;
    w_do_adv    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          plane_d    = plane;
          row_base_d = w_start_base;
          wr_idx_d   = 6'd0;
          addr_a_d   = 7'd0;
          addr_b_d   = 7'd1;
          busy_d     = 1'b1;
          state_d    = S_LEADIN1;
        end
      end
      S_LEADIN1: begin
        w_do_adv = 1'b1;
        state_d  = S_LEADIN2;
      end
      S_LEADIN2: begin
        w_do_write = 1'b1;
        w_do_adv   = 1'b1;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (wr_idx_q == 6'd32) begin
          finish_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          w_do_write = 1'b1;
          w_do_adv   = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Read addresses run two words ahead of the write and park on word 31.
    if (w_do_adv && (w_rd_k != 5'd31)) begin
      addr_a_d = {1'b0, w_rd_k + 5'd1, 1'b0};
      addr_b_d = {1'b0, w_rd_k + 5'd1, 1'b1};
    end

    if (w_do_write) begin
      sram_addr_d = row_base_q + 18'(wr_idx_q[1:0]);
      wdata_d     = {clip_pix(Data_out_S_a), clip_pix(Data_out_S_b)};
      we_n_d      = (plane_q == 2'd3);
      wr_idx_d    = wr_idx_q + 6'd1;
      if (wr_idx_q[1:0] == 2'd3)
        row_base_d = row_base_q + w_wpr_q;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      plane_q     <= 2'd0;
      row_base_q  <= 18'd0;
      wr_idx_q    <= 6'd0;
      addr_a_q    <= 7'd0;
      addr_b_q    <= 7'd0;
      sram_addr_q <= 18'd0;
      wdata_q     <= 16'd0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      plane_q     <= plane_d;
      row_base_q  <= row_base_d;
      wr_idx_q    <= wr_idx_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

  assign Address_S_a     = addr_a_q;
  assign Address_S_b     = addr_b_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign busy            = busy_q;
  assign finish          = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_write_s_block.sv
`default_nettype none
// ============================================================================
//  Module   : tb_write_s_block
//  Purpose  : Self-checking bench for write_s_block. An S RAM model feeds the
//             DUT; every write, finish pulse and busy cycle is recorded per
//             block and compared with a plain-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_write_s_block;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  plane = 2'd0;
  logic [4:0]  block_row = 5'd0;
  logic [5:0]  block_col = 6'd0;
  logic [6:0]  Address_S_a, Address_S_b;
  logic [31:0] Data_out_S_a = 32'd0, Data_out_S_b = 32'd0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, busy, finish;

  int checks = 0;
  int failures = 0;

  logic [31:0] s_mem [0:63];

  logic [17:0] obs_addr[$];
  logic [15:0] obs_data[$];
  int          obs_edge[$];
  int          fin_edge[$];
  int          busy_cnt;
  logic [17:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];

  logic [6:0]  snap_aa, snap_ab;
  logic [17:0] snap_sa;
  logic [15:0] snap_wd;
  logic        snap_we, snap_busy, snap_fin;

  always #5 clk = ~clk;

  // S RAM with one-cycle read latency on both ports.
  always @(posedge clk) begin
    Data_out_S_a <= s_mem[Address_S_a[5:0]];
    Data_out_S_b <= s_mem[Address_S_b[5:0]];
  end

  write_s_block dut (
    .Clock_50        (clk),
    .Reset           (Reset),
    .start           (start),
    .plane           (plane),
    .block_row       (block_row),
    .block_col       (block_col),
    .Address_S_a     (Address_S_a),
    .Data_out_S_a    (Data_out_S_a),
    .Address_S_b     (Address_S_b),
    .Data_out_S_b    (Data_out_S_b),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .busy            (busy),
    .finish          (finish)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_pix(input logic [31:0] s);
    longint v;
    v = longint'($signed(s)) / 65536;  // negatives clip to 0 either way
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  task automatic build_expected(input int pl, input int br, input int bc);
    int base, wpr, a;
    exp_addr_q.delete();
    exp_data_q.delete();
    base = (pl == 0) ? 0 : (pl == 1) ? 38400 : 57600;
    wpr  = (pl == 0) ? 160 : 80;
    for (int k = 0; k < 32; k++) begin
      a = base + (8 * br + k / 4) * wpr + 4 * bc + (k % 4);
      exp_addr_q.push_back(18'(a));
      exp_data_q.push_back({ref_pix(s_mem[2*k]), ref_pix(s_mem[2*k+1])});
    end
  endtask

  task automatic fill_random_s();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0)
        s_mem[i] = $urandom;
      else
        s_mem[i] = 32'(int'($urandom_range(0, 26214400)) - 4194304);
    end
  endtask

  // Drives one block (start sampled at edge 0) and records observations.
  // Outputs are sampled 1 time unit after each rising edge.
  task automatic run_block(input logic [1:0] pl, input logic [4:0] br, input logic [5:0] bc,
                           input int hold_until, input int pulse_at, input int rst_at,
                           input int n_cycles);
    obs_addr.delete(); obs_data.delete(); obs_edge.delete(); fin_edge.delete();
    busy_cnt = 0;
    plane = pl; block_row = br; block_col = bc;
    start = 1'b1; Reset = 1'b0;
    for (int e = 0; e < n_cycles; e++) begin
      @(posedge clk);
      #1;
      if (SRAM_we_n === 1'b0) begin
        obs_addr.push_back(SRAM_address);
        obs_data.push_back(SRAM_write_data);
        obs_edge.push_back(e);
      end
      if (finish === 1'b1) fin_edge.push_back(e);
      if (busy === 1'b1) busy_cnt++;
      if (e == rst_at) begin
        snap_aa = Address_S_a; snap_ab = Address_S_b; snap_sa = SRAM_address;
        snap_wd = SRAM_write_data; snap_we = SRAM_we_n; snap_busy = busy; snap_fin = finish;
      end
      start = ((e + 1) <= hold_until) || ((e + 1) == pulse_at);
      Reset = ((e + 1) == rst_at);
      if (hold_until <= 0) begin
        plane     = 2'($urandom);
        block_row = 5'($urandom);
        block_col = 6'($urandom);
      end
    end
    start = 1'b0;
    Reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Address_S_a !== 7'd0 || Address_S_b !== 7'd0)
      begin failures++; $display("FAIL reset_saddr: a=%0d b=%0d expected 0 0", Address_S_a, Address_S_b); end
    checks++;
    if (SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0)
      begin failures++; $display("FAIL reset_sram: addr=%0d data=%h expected 0 0000", SRAM_address, SRAM_write_data); end
    checks++;
    if (SRAM_we_n !== 1'b1 || busy !== 1'b0 || finish !== 1'b0)
      begin failures++; $display("FAIL reset_ctrl: we_n=%b busy=%b finish=%b expected 1 0 0", SRAM_we_n, busy, finish); end
    // start coincident with Reset must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || SRAM_we_n !== 1'b1)
      begin failures++; $display("FAIL reset_vs_start: busy=%b we_n=%b expected 0 1", busy, SRAM_we_n); end
  endtask

  task automatic test_basic_y();
    for (int i = 0; i < 64; i++) s_mem[i] = 32'h0080_0000;
    build_expected(0, 0, 0);
    run_block(2'd0, 5'd0, 6'd0, 0, -1, -1, 38);
    checks++;
    if (obs_addr.size() != 32)
      begin failures++; $display("FAIL y_count: writes=%0d expected 32", obs_addr.size()); end
    for (int k = 0; k < obs_addr.size() && k < 32; k++) begin
      checks++;
      if (obs_addr[k] !== exp_addr_q[k] || obs_data[k] !== 16'h8080 || obs_edge[k] != k + 2)
        begin failures++; $display("FAIL y_word%0d: addr=%0d data=%h edge=%0d expected %0d 8080 %0d",
                                   k, obs_addr[k], obs_data[k], obs_edge[k], exp_addr_q[k], k + 2); end
    end
    checks++;
    if (fin_edge.size() != 1 || fin_edge[0] != 34)
      begin failures++; $display("FAIL y_finish: pulses=%0d edge=%0d expected 1 34",
                                 fin_edge.size(), (fin_edge.size() > 0) ? fin_edge[0] : -1); end
    checks++;
    if (busy_cnt != 35)
      begin failures++; $display("FAIL y_busy: cycles=%0d expected 35", busy_cnt); end
  endtask

  task automatic test_clip();
    fill_random_s();
    s_mem[0] = 32'h00FF_FFFF; s_mem[1] = 32'h0100_0000;
    s_mem[2] = 32'hFFFF_0000; s_mem[3] = 32'h0000_FFFF;
    build_expected(0, 7, 13);
    run_block(2'd0, 5'd7, 6'd13, 0, -1, -1, 38);
    checks++;
    if (obs_data.size() < 2 || obs_data[0] !== 16'hFFFF || obs_data[1] !== 16'h0000)
      begin failures++; $display("FAIL clip_words: w0=%h w1=%h expected ffff 0000",
                                 (obs_data.size() > 0) ? obs_data[0] : 16'hxxxx,
                                 (obs_data.size() > 1) ? obs_data[1] : 16'hxxxx); end
    checks++;
    if (obs_addr.size() != 32)
      begin failures++; $display("FAIL clip_count: writes=%0d expected 32", obs_addr.size()); end
    for (int k = 0; k < obs_addr.size() && k < 32; k++) begin
      checks++;
      if (obs_addr[k] !== exp_addr_q[k] || obs_data[k] !== exp_data_q[k])
        begin failures++; $display("FAIL clip_word%0d: addr=%0d data=%h expected %0d %h",
                                   k, obs_addr[k], obs_data[k], exp_addr_q[k], exp_data_q[k]); end
    end
  endtask

  task automatic test_uv_corner();
    for (int i = 0; i < 64; i++) s_mem[i] = 32'(i) << 16;
    build_expected(1, 29, 19);
    run_block(2'd1, 5'd29, 6'd19, 0, -1, -1, 38);
    checks++;
    if (obs_addr.size() != 32)
      begin failures++; $display("FAIL u_count: writes=%0d expected 32", obs_addr.size()); end
    else begin
      checks++;
      if (obs_addr[0] !== 18'd57036 || obs_data[0] !== 16'h0001)
        begin failures++; $display("FAIL u_first: addr=%0d data=%h expected 57036 0001", obs_addr[0], obs_data[0]); end
      checks++;
      if (obs_addr[31] !== 18'd57599 || obs_data[31] !== 16'h3E3F)
        begin failures++; $display("FAIL u_last: addr=%0d data=%h expected 57599 3e3f", obs_addr[31], obs_data[31]); end
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (obs_addr[k] !== exp_addr_q[k] || obs_data[k] !== exp_data_q[k])
          begin failures++; $display("FAIL u_word%0d: addr=%0d data=%h expected %0d %h",
                                     k, obs_addr[k], obs_data[k], exp_addr_q[k], exp_data_q[k]); end
      end
    end
    run_block(2'd2, 5'd0, 6'd0, 0, -1, -1, 38);
    checks++;
    if (obs_addr.size() != 32 || obs_addr[0] !== 18'd57600)
      begin failures++; $display("FAIL v_first: writes=%0d addr=%0d expected 32 57600",
                                 obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 18'h3FFFF); end
  endtask

  task automatic test_random_blocks();
    logic [1:0] pl;
    logic [4:0] br;
    logic [5:0] bc;
    int err;
    for (int n = 0; n < 6; n++) begin
      fill_random_s();
      pl = 2'($urandom_range(0, 2));
      br = 5'($urandom_range(0, 29));
      bc = 6'((pl == 2'd0) ? $urandom_range(0, 39) : $urandom_range(0, 19));
      build_expected(int'(pl), int'(br), int'(bc));
      run_block(pl, br, bc, 0, -1, -1, 38);
      err = 0;
      for (int k = 0; k < obs_addr.size() && k < 32; k++)
        if (obs_addr[k] !== exp_addr_q[k] || obs_data[k] !== exp_data_q[k] || obs_edge[k] != k + 2) err++;
      checks++;
      if (obs_addr.size() != 32 || err != 0 || fin_edge.size() != 1)
        begin failures++; $display("FAIL rand_block%0d: plane=%0d row=%0d col=%0d writes=%0d bad_words=%0d finishes=%0d expected 32 0 1",
                                   n, pl, br, bc, obs_addr.size(), err, fin_edge.size()); end
    end
  endtask

  task automatic test_back_to_back();
    int err;
    fill_random_s();
    build_expected(0, 2, 3);
    // start held through edge 36, extra pulse at edge 10
    run_block(2'd0, 5'd2, 6'd3, 36, 10, -1, 74);
    err = 0;
    for (int k = 0; k < obs_addr.size() && k < 64; k++)
      if (obs_addr[k] !== exp_addr_q[k % 32] || obs_data[k] !== exp_data_q[k % 32] ||
          obs_edge[k] != ((k < 32) ? k + 2 : k + 6)) err++;
    checks++;
    if (obs_addr.size() != 64 || err != 0)
      begin failures++; $display("FAIL b2b_writes: writes=%0d bad=%0d expected 64 0", obs_addr.size(), err); end
    checks++;
    if (fin_edge.size() != 2 || fin_edge[0] != 34 || fin_edge[1] != 70)
      begin failures++; $display("FAIL b2b_finish: pulses=%0d first=%0d expected 2 34",
                                 fin_edge.size(), (fin_edge.size() > 0) ? fin_edge[0] : -1); end
  endtask

  task automatic test_reset_mid();
    fill_random_s();
    run_block(2'd1, 5'd3, 6'd5, 0, -1, 12, 40);
    checks++;
    if (snap_we !== 1'b1 || snap_busy !== 1'b0 || snap_fin !== 1'b0)
      begin failures++; $display("FAIL rstmid_ctrl: we_n=%b busy=%b finish=%b expected 1 0 0", snap_we, snap_busy, snap_fin); end
    checks++;
    if (snap_aa !== 7'd0 || snap_ab !== 7'd0 || snap_sa !== 18'd0 || snap_wd !== 16'd0)
      begin failures++; $display("FAIL rstmid_data: a=%0d b=%0d addr=%0d data=%h expected 0 0 0 0000",
                                 snap_aa, snap_ab, snap_sa, snap_wd); end
    checks++;
    if (obs_addr.size() != 10 || fin_edge.size() != 0)
      begin failures++; $display("FAIL rstmid_stop: writes=%0d finishes=%0d expected 10 0", obs_addr.size(), fin_edge.size()); end
    build_expected(1, 3, 5);
    run_block(2'd1, 5'd3, 6'd5, 0, -1, -1, 38);
    checks++;
    if (obs_addr.size() != 32 || obs_addr[0] !== exp_addr_q[0] || obs_data[31] !== exp_data_q[31] ||
        fin_edge.size() != 1)
      begin failures++; $display("FAIL rstmid_recover: writes=%0d finishes=%0d expected 32 1", obs_addr.size(), fin_edge.size()); end
  endtask

  task automatic test_plane3();
    fill_random_s();
    run_block(2'd3, 5'd4, 6'd4, 0, -1, -1, 38);
    checks++;
    if (obs_addr.size() != 0)
      begin failures++; $display("FAIL p3_writes: writes=%0d expected 0", obs_addr.size()); end
    checks++;
    if (fin_edge.size() != 1 || fin_edge[0] != 34 || busy_cnt != 35)
      begin failures++; $display("FAIL p3_timing: pulses=%0d edge=%0d busy=%0d expected 1 34 35",
                                 fin_edge.size(), (fin_edge.size() > 0) ? fin_edge[0] : -1, busy_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) s_mem[i] = 32'd0;
    @(negedge clk);
    test_reset();
    test_basic_y();
    test_clip();
    test_uv_corner();
    test_random_blocks();
    test_back_to_back();
    test_reset_mid();
    test_plane3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
